jericalla_pipe: RTL and testbench
=================================

Name: jericalla_pipe

Overview:
- Parametrised three-stage pipelined datapath: register file, ALU, data memory and control in one block.
- Executes one instruction per clock with full operand forwarding, so no data-hazard stalls are needed.
- Adds immediate load, memory load with a valid/ready result stream, and whole-pipeline backpressure.
- Instructions arrive through a valid/ready input; loaded words leave through a valid/ready output.

Parameters:
- DATA_W, 32, datapath, register and memory word width.
- REG_ADDR_W, 5, register address width; the register file holds 2^REG_ADDR_W words.
- MEM_ADDR_W, 5, data memory address width; the memory holds 2^MEM_ADDR_W words.
- INSTR_W (localparam), 3+3*REG_ADDR_W, instruction width; 18 at defaults.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruccion is valid.
- in_ready  output  1  block can accept an instruction.
- instruccion  input  INSTR_W  instruction fields, MSB first: opcode[2:0], WA, RA1, RA2.
- out_valid  output  1  out_data holds a loaded word.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  DATA_W  word returned by LW.

Behaviour:
- Opcodes:
  - 000 ADD: WA=RA1+RA2.
  - 001 SUB: WA=RA1-RA2.
  - 010 AND.
  - 011 OR.
  - 100 SLT: WA=1 if RA1<RA2 signed, else 0.
  - 101 LI: WA={RA1,RA2} as a 2*REG_ADDR_W-bit immediate, zero-extended.
  - 110 SW: mem[RA1 value]=RA2 value; WA ignored.
  - 111 LW: WA=mem[RA1 value].
- Arithmetic: modulo 2^DATA_W, no flags. The memory address is the low MEM_ADDR_W bits of the RA1 value, so addresses wrap.
- Accept: an instruction is accepted on a rising edge with in_valid && in_ready. in_valid=0 inserts a bubble.
- Pipeline stages:
  - ID (acceptance cycle): register file read combinationally; decoded fields and operands captured into the EX register at the accept edge.
  - EX (next cycle): ALU result or address computed; captured into the WB register.
  - WB (next cycle): all side effects happen at the edge that ends the WB cycle: register write, memory write, LW register write.
- Latency: for an instruction accepted at edge k, side effects occur at edge k+2. For LW, out_valid is high in the cycle between edges k+1 and k+2.
- Forwarding:
  - A valid WB instruction that writes WA (ALU, LI, LW) forwards its result to EX operands whose address matches WA. For LW the forwarded value is the combinational memory read.
  - The register file is write-through: an ID read of a register being written the same cycle returns the new value.
  - SW never forwards.
- Memory read/write ordering: memory reads are asynchronous. An SW in WB writes at the edge, so an LW in the following cycle sees the new data.
- Backpressure:
  - stall = WB valid && WB is LW && !out_ready.
  - in_ready = !stall.
  - While stalled, all stage registers, register file and memory hold. out_valid and out_data stay stable.
  - The stuck LW retires, writing its register, at the first edge where out_ready=1.
- Stall exit: forwarding stays correct when a stall ends. The EX consumer captures the forwarded value at the same edge the producer retires.
- Simultaneous events: register writes from WB and reads in ID coincide under write-through. No other structural conflicts exist.
- Reset (rst_n low, asynchronous):
  - All stage valid bits cleared.
  - All registers and memory words set to 0.
  - Outputs: out_valid=0, out_data=0, in_ready=1.
  - Reset mid-operation discards all in-flight instructions and their pending side effects.
- out_data is 0 whenever out_valid=0.

Test Plan:
- Reset: drive rst_n=0 mid-clock -> out_valid=0 and in_ready=1 immediately; every register reads 0 via ADD of r0,r0 followed by SW/LW.
- Back-to-back dependencies, out_ready=1: LI r1,5; LI r2,3; ADD r3,r1,r2; SW [r1],r3; LW r4,[r1] -> out_data=8 with out_valid high for 1 cycle, 2 edges after the LW accept.
- Arithmetic: with r1=5, r2=3, run SUB r5,r2,r1 then SLT r6,r5,r1 -> r5=0xFFFFFFFE, r6=1 (signed); run SLT r7,r1,r2 -> r7=0.
- Backpressure: LW r4 with out_ready=0 for 3 cycles, ADD r8,r4,r4 issued next -> out_valid and out_data=8 held for 3 cycles, in_ready=0; after release the ADD gives r8=16.
- Wrap: LI r9,37; SW [r9],r2; LI r10,5; LW r11,[r10] -> out_data=3 at MEM_ADDR_W=5.
- Reset mid-flight: assert rst_n=0 while an LW is in WB with out_ready=0 -> out_valid falls at once; the LW target register reads 0 after reset.

Source files
------------

// File: rtl/jericalla_pipe.sv
// jericalla_pipe: three-stage ID/EX/WB datapath with forwarding,
// immediate/memory loads, and a valid/ready load-result stream.
module jericalla_pipe #(
  parameter  int DATA_W     = 32,
  parameter  int REG_ADDR_W = 5,
  parameter  int MEM_ADDR_W = 5,
  localparam int INSTR_W    = 3 + 3 * REG_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruccion,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data
);

  localparam int RW   = REG_ADDR_W;
  localparam int NREG = 2 ** REG_ADDR_W;
  localparam int NMEM = 2 ** MEM_ADDR_W;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_LI  = 3'b101;
  localparam logic [2:0] OP_SW  = 3'b110;
  localparam logic [2:0] OP_LW  = 3'b111;

  logic [DATA_W-1:0] rf  [NREG];
  logic [DATA_W-1:0] mem [NMEM];

  logic [2:0]    id_op;
  logic [RW-1:0] id_wa;
  logic [RW-1:0] id_ra1;
  logic [RW-1:0] id_ra2;

  logic              ex_valid;
  logic [2:0]        ex_op;
  logic [RW-1:0]     ex_wa;
  logic [RW-1:0]     ex_ra1;
  logic [RW-1:0]     ex_ra2;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;

  logic                  wb_valid;
  logic [2:0]            wb_op;
  logic [RW-1:0]         wb_wa;
  logic [DATA_W-1:0]     wb_res;
  logic [MEM_ADDR_W-1:0] wb_addr;

  logic                  wb_wr;
  logic                  wb_lw;
  logic [DATA_W-1:0]     wb_val;
  logic                  stall;
  logic                  accept;
  logic [DATA_W-1:0]     id_a;
  logic [DATA_W-1:0]     id_b;
  logic [DATA_W-1:0]     fa;
  logic [DATA_W-1:0]     fb;
  logic [DATA_W-1:0]     ex_res;
  logic [DATA_W-1:0]     ex_imm;
  logic [MEM_ADDR_W-1:0] ex_addr;

  assign id_op  = instruccion[INSTR_W-1 -: 3];
  assign id_wa  = instruccion[3*RW-1 -: RW];
  assign id_ra1 = instruccion[2*RW-1 -: RW];
  assign id_ra2 = instruccion[RW-1:0];

  assign wb_lw    = wb_valid && (wb_op == OP_LW);
  assign wb_wr    = wb_valid && (wb_op != OP_SW);
  assign wb_val   = wb_lw ? mem[wb_addr] : wb_res;
  assign stall    = wb_lw && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  assign out_valid = wb_lw;
  assign out_data  = wb_lw ? mem[wb_addr] : '0;

  // ID read with write-through; EX operands forwarded from WB
  always_comb begin
    id_a = rf[id_ra1];
    id_b = rf[id_ra2];
    fa   = ex_a;
    fb   = ex_b;
    if (wb_wr && (wb_wa == id_ra1)) id_a = wb_val;
    if (wb_wr && (wb_wa == id_ra2)) id_b = wb_val;
    if (wb_wr && (wb_wa == ex_ra1)) fa = wb_val;
    if (wb_wr && (wb_wa == ex_ra2)) fb = wb_val;
  end

  assign ex_imm  = {{(DATA_W-2*RW){1'b0}}, ex_ra1, ex_ra2};
  assign ex_addr = fa[MEM_ADDR_W-1:0];

  // EX-stage ALU; SW carries its store data in the result slot
  always_comb begin
    ex_res = '0;
    unique case (1'b1)
      (ex_op == OP_ADD): ex_res = fa + fb;
      (ex_op == OP_SUB): ex_res = fa - fb;
      (ex_op == OP_AND): ex_res = fa & fb;
      (ex_op == OP_OR):  ex_res = fa | fb;
      (ex_op == OP_SLT):
        ex_res = {{(DATA_W-1){1'b0}},
                  ($signed(fa) < $signed(fb))};
      (ex_op == OP_LI):  ex_res = ex_imm;
      (ex_op == OP_SW):  ex_res = fb;
      (ex_op == OP_LW):  ex_res = '0;
      default:           ex_res = '0;
    endcase
  end

  // Stage registers advance together unless a load is stuck in WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_wa    <= '0;
      ex_ra1   <= '0;
      ex_ra2   <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      wb_valid <= 1'b0;
      wb_op    <= '0;
      wb_wa    <= '0;
      wb_res   <= '0;
      wb_addr  <= '0;
    end else if (!stall) begin
      ex_valid <= accept;
      if (accept) begin
        ex_op  <= id_op;
        ex_wa  <= id_wa;
        ex_ra1 <= id_ra1;
        ex_ra2 <= id_ra2;
        ex_a   <= id_a;
        ex_b   <= id_b;
      end
      wb_valid <= ex_valid;
      if (ex_valid) begin
        wb_op   <= ex_op;
        wb_wa   <= ex_wa;
        wb_res  <= ex_res;
        wb_addr <= ex_addr;
      end
    end
  end

  // Register file: WB retirement write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_wr && !stall) begin
      rf[wb_wa] <= wb_val;
    end
  end

  // Data memory: SW commit at the end of WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NMEM; i++) mem[i] <= '0;
    end else if (wb_valid && (wb_op == OP_SW)) begin
      mem[wb_addr] <= wb_res;
    end
  end

endmodule

// File: tb/tb_jericalla_pipe.sv
// tb_jericalla_pipe: directed and randomized checks of jericalla_pipe
// against an in-order architectural model.
module tb_jericalla_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] instruccion;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks;
  int errors;
  bit rnd_done;

  logic [31:0] mregs [32];
  logic [31:0] mmem  [32];
  logic [31:0] expq  [$];

  jericalla_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruccion (instruccion),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk(
    input logic [2:0] op, input logic [4:0] wa,
    input logic [4:0] ra1, input logic [4:0] ra2);
    return {op, wa, ra1, ra2};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mmem[i]  = '0;
    end
    expq.delete();
  endtask

  task automatic model(input logic [17:0] ins);
    logic [2:0]  op;
    logic [4:0]  wa, r1, r2;
    logic [31:0] a, b, v;
    op = ins[17:15];
    wa = ins[14:10];
    r1 = ins[9:5];
    r2 = ins[4:0];
    a  = mregs[r1];
    b  = mregs[r2];
    case (op)
      3'd0: mregs[wa] = a + b;
      3'd1: mregs[wa] = a - b;
      3'd2: mregs[wa] = a & b;
      3'd3: mregs[wa] = a | b;
      3'd4: mregs[wa] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: mregs[wa] = {22'd0, r1, r2};
      3'd6: mmem[a[4:0]] = b;
      default: begin
        v = mmem[a[4:0]];
        mregs[wa] = v;
        expq.push_back(v);
      end
    endcase
  endtask

  // Every delivered load word is compared with the model's prediction
  always @(negedge clk) begin
    if (rst_n) begin
      if (!out_valid && out_data !== 32'd0) begin
        checks++;
        errors++;
        $display("FAIL idle_data: got %h want 0", out_data);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load: got %h, none expected",
                   out_data);
        end else begin
          logic [31:0] e;
          e = expq.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL load_data: got %h want %h", out_data, e);
          end
        end
      end
    end
  end

  task automatic issue(input logic [17:0] ins);
    int n;
    n = 0;
    @(negedge clk);
    in_valid    = 1'b1;
    instruccion = ins;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    model(ins);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d loads pending want 0", expq.size());
    end
  endtask

  task automatic readreg(input logic [4:0] r, output logic [31:0] v);
    drain();
    issue(mk(3'd5, 5'd31, 5'd0, 5'd0));
    issue(mk(3'd6, 5'd0, 5'd31, r));
    issue(mk(3'd7, 5'd31, 5'd31, 5'd0));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL readreg_valid r%0d: got %b want 1", r, out_valid);
    end
    v = out_data;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b r=%b d=%h want 0 1 0",
               out_valid, in_ready, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(mk(3'd0, 5'd0, 5'd0, 5'd0));
    for (int i = 0; i < 31; i++) begin
      readreg(i[4:0], v);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg r%0d: got %h want 0", i, v);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(mk(3'd5, 5'd1, 5'd0, 5'd5));
    issue(mk(3'd5, 5'd2, 5'd0, 5'd3));
    issue(mk(3'd0, 5'd3, 5'd1, 5'd2));
    issue(mk(3'd6, 5'd0, 5'd1, 5'd3));
    issue(mk(3'd7, 5'd4, 5'd1, 5'd0));
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_early: out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd8) begin
      errors++;
      $display("FAIL b2b_load: v=%b d=%h want 1 8",
               out_valid, out_data);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_late: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_arith();
    logic [31:0] v;
    issue(mk(3'd1, 5'd5, 5'd2, 5'd1));
    issue(mk(3'd4, 5'd6, 5'd5, 5'd1));
    issue(mk(3'd4, 5'd7, 5'd1, 5'd2));
    readreg(5'd5, v);
    checks++;
    if (v !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL sub: got %h want fffffffe", v);
    end
    readreg(5'd6, v);
    checks++;
    if (v !== 32'd1) begin
      errors++;
      $display("FAIL slt_neg: got %h want 1", v);
    end
    readreg(5'd7, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL slt_pos: got %h want 0", v);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v;
    drain();
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(mk(3'd7, 5'd4, 5'd1, 5'd0));
    issue(mk(3'd0, 5'd8, 5'd4, 5'd4));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd8 ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold %0d: v=%b d=%h r=%b want 1 8 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    readreg(5'd8, v);
    checks++;
    if (v !== 32'd16) begin
      errors++;
      $display("FAIL stall_fwd: got %h want 10", v);
    end
  endtask

  task automatic test_wrap();
    drain();
    issue(mk(3'd5, 5'd9, 5'd1, 5'd5));
    issue(mk(3'd6, 5'd0, 5'd9, 5'd2));
    issue(mk(3'd5, 5'd10, 5'd0, 5'd5));
    issue(mk(3'd7, 5'd11, 5'd10, 5'd0));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd3) begin
      errors++;
      $display("FAIL wrap: v=%b d=%h want 1 3", out_valid, out_data);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] v;
    drain();
    issue(mk(3'd5, 5'd13, 5'd0, 5'd7));
    issue(mk(3'd5, 5'd14, 5'd3, 5'd3));
    issue(mk(3'd6, 5'd0, 5'd13, 5'd14));
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(mk(3'd7, 5'd12, 5'd13, 5'd0));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd99) begin
      errors++;
      $display("FAIL mid_pre: v=%b d=%h want 1 63",
               out_valid, out_data);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: v=%b d=%h r=%b want 0 0 1",
               out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    readreg(5'd12, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL mid_reg: got %h want 0", v);
    end
  endtask

  task automatic test_random();
    logic [17:0] ins;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          ins = mk($urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7));
          if (ins[17:15] == 3'd5) ins[9:0] = 10'($urandom);
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          issue(ins);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    instruccion = '0;
    out_ready   = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_back_to_back();
    test_arith();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
